test_stream_source: RTL and testbench

Counterpart transmitter to the test stream sink. On a start pulse it emits a single AXI4-stream packet of incrementing 32-bit words (0, 1, 2, …), asserting tlast on the final beat. Gaps between beats and single-sample skips are programmable, so downstream sinks and DMA paths can be exercised for bandwidth and sample-loss detection. It also counts accepted beats and back-pressure stalls for software readout.

---
 rtl/test_stream_source_pkg.sv | 8 +
 rtl/test_stream_source_event_counter_async.sv | 17 +
 rtl/test_stream_source.sv | 86 ++++++++
 tb/tb_test_stream_source.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/test_stream_source_pkg.sv
// test_stream_source_pkg: shared FSM encoding and default widths for the test stream source
package test_stream_source_pkg;
   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_COUNT_WIDTH = 32;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;
endpackage

// File: rtl/test_stream_source_event_counter_async.sv
// event_counter_async: wrap-around event counter with async active-low reset and sync clear
module event_counter_async #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_count
);
   logic [W-1:0] r_count;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) r_count <= '0;
      else if (i_clr) r_count <= '0;
      else if (i_en) r_count <= r_count + W'(1);
   assign o_count = r_count;
endmodule

// File: rtl/test_stream_source.sv
// test_stream_source: emits one AXI4-stream packet of incrementing words per start pulse,
// with programmable inter-beat gaps, injectable sample skips and beat/stall/skip counters.
module test_stream_source
   import test_stream_source_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   start,
   output logic                   idle,
   input  logic [COUNT_WIDTH-1:0] packet_length,
   input  logic [7:0]             gap_cycles,
   input  logic                   inject_skip,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic [DATA_WIDTH-1:0]  m_tdata,
   output logic                   m_tlast,
   output logic [COUNT_WIDTH-1:0] beat_count,
   output logic [COUNT_WIDTH-1:0] stall_count,
   output logic [COUNT_WIDTH-1:0] skip_count
);
   logic [1:0]             r_state;
   logic [COUNT_WIDTH-1:0] r_len, r_idx;
   logic [7:0]             r_gap, r_gap_cnt;
   logic [DATA_WIDTH-1:0]  r_data;
   logic                   r_skip_pend;
   logic w_idle, w_send, w_start, w_last, w_hs, w_adv, w_skip;

   assign w_idle  = r_state == S_IDLE;
   assign w_send  = r_state == S_SEND;
   assign w_start = start & w_idle;
   assign w_last  = r_idx == r_len - COUNT_WIDTH'(1);
   assign w_hs    = w_send & m_tready;
   assign w_adv   = w_hs & ~w_last;
   // a pulse arriving on the handshake cycle itself skips that very increment
   assign w_skip  = r_skip_pend | inject_skip;

   assign idle     = w_idle;
   assign m_tvalid = w_send;
   assign m_tlast  = w_send & w_last;
   assign m_tdata  = r_data;

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_len       <= '0;
         r_idx       <= '0;
         r_gap       <= '0;
         r_gap_cnt   <= '0;
         r_data      <= '0;
         r_skip_pend <= 1'b0;
      end else begin
         r_skip_pend <= (w_idle | w_hs) ? 1'b0 : r_skip_pend | inject_skip;
         if (w_start && packet_length != '0) begin
            r_state <= S_SEND;
            r_len   <= packet_length;
            r_gap   <= gap_cycles;
            r_data  <= '0;
            r_idx   <= '0;
         end else if (w_adv) begin
            r_data <= r_data + (w_skip ? DATA_WIDTH'(2) : DATA_WIDTH'(1));
            r_idx  <= r_idx + COUNT_WIDTH'(1);
            if (r_gap != 8'd0) begin
               r_state   <= S_GAP;
               r_gap_cnt <= r_gap;
            end
         end else if (w_hs) begin
            r_state <= S_IDLE;
         end else if (r_state == S_GAP) begin
            if (r_gap_cnt == 8'd1) r_state <= S_SEND;
            r_gap_cnt <= r_gap_cnt - 8'd1;
         end
      end

   event_counter_async #(.W(COUNT_WIDTH)) u_beat (
      .clk(clk), .resetn(resetn), .i_clr(w_start), .i_en(w_hs), .o_count(beat_count)
   );
   event_counter_async #(.W(COUNT_WIDTH)) u_stall (
      .clk(clk), .resetn(resetn), .i_clr(w_start), .i_en(w_send & ~m_tready), .o_count(stall_count)
   );
   event_counter_async #(.W(COUNT_WIDTH)) u_skip (
      .clk(clk), .resetn(resetn), .i_clr(w_start), .i_en(w_adv & w_skip), .o_count(skip_count)
   );
endmodule

// File: tb/tb_test_stream_source.sv
// tb_test_stream_source: directed vectors with hand-computed expectations for test_stream_source
module tb_test_stream_source;
   logic        clk = 1'b0;
   logic        resetn, start, inject_skip, m_tready;
   logic [31:0] packet_length;
   logic [7:0]  gap_cycles;
   logic        idle, m_tvalid, m_tlast;
   logic [31:0] m_tdata, beat_count, stall_count, skip_count;
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   test_stream_source dut (
      .clk(clk), .resetn(resetn), .start(start), .idle(idle),
      .packet_length(packet_length), .gap_cycles(gap_cycles), .inject_skip(inject_skip),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
      .beat_count(beat_count), .stall_count(stall_count), .skip_count(skip_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic kick(input logic [31:0] len, input logic [7:0] gap);
      packet_length = len;
      gap_cycles    = gap;
      start         = 1'b1;
      tick();
      start         = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; start = 1'b0; inject_skip = 1'b0; m_tready = 1'b1;
      packet_length = 0; gap_cycles = 0;
      #12;
      check("rst_idle", idle, 1);
      check("rst_valid", m_tvalid, 0);
      check("rst_last", m_tlast, 0);
      check("rst_data", m_tdata, 0);
      check("rst_beat", beat_count, 0);
      check("rst_stall", stall_count, 0);
      check("rst_skip", skip_count, 0);
      resetn = 1'b1;
      tick();

      // back-to-back packet of 4
      kick(4, 0);
      check("b2b_idle_low", idle, 0);
      for (int i = 0; i < 4; i++) begin
         check("b2b_valid", m_tvalid, 1);
         check("b2b_data", m_tdata, i);
         check("b2b_last", m_tlast, (i == 3) ? 1 : 0);
         tick();
      end
      check("b2b_idle", idle, 1);
      check("b2b_valid_end", m_tvalid, 0);
      check("b2b_beat", beat_count, 4);
      check("b2b_stall", stall_count, 0);

      // length 3 with 2-cycle gaps; tready low during gaps is don't-care
      kick(3, 2);
      for (int c = 0; c < 7; c++) begin
         m_tready = (c % 3 == 0);
         check("gap_valid", m_tvalid, (c % 3 == 0) ? 1 : 0);
         if (c % 3 == 0) check("gap_data", m_tdata, c / 3);
         tick();
      end
      m_tready = 1'b1;
      check("gap_idle", idle, 1);
      check("gap_beat", beat_count, 3);
      check("gap_stall", stall_count, 0);

      // back-pressure for 5 cycles on beat 1
      kick(4, 0);
      check("bp_d0", m_tdata, 0);
      tick();
      m_tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_valid", m_tvalid, 1);
         check("bp_hold_data", m_tdata, 1);
         tick();
      end
      m_tready = 1'b1;
      check("bp_hold_data2", m_tdata, 1);
      tick();
      check("bp_d2", m_tdata, 2);
      tick();
      check("bp_d3", m_tdata, 3);
      check("bp_last", m_tlast, 1);
      tick();
      check("bp_idle", idle, 1);
      check("bp_stall", stall_count, 5);
      check("bp_beat", beat_count, 4);

      // skip injection while beat 1 is stalled, second pulse absorbed
      kick(5, 0);
      check("sk_d0", m_tdata, 0);
      tick();
      check("sk_d1", m_tdata, 1);
      m_tready = 1'b0; inject_skip = 1'b1;
      tick();
      inject_skip = 1'b0;
      tick();
      inject_skip = 1'b1;
      tick();
      inject_skip = 1'b0;
      check("sk_d1_hold", m_tdata, 1);
      m_tready = 1'b1;
      tick();
      check("sk_d3", m_tdata, 3);
      tick();
      check("sk_d4", m_tdata, 4);
      tick();
      check("sk_d5", m_tdata, 5);
      check("sk_last", m_tlast, 1);
      tick();
      check("sk_idle", idle, 1);
      check("sk_skip", skip_count, 1);
      check("sk_beat", beat_count, 5);
      check("sk_stall", stall_count, 3);

      // start pulses mid-packet are ignored
      kick(6, 1);
      for (int c = 0; c < 11; c++) begin
         if (c == 3 || c == 4) begin
            start = 1'b1; packet_length = 2; gap_cycles = 0;
         end else start = 1'b0;
         check("mid_valid", m_tvalid, (c % 2 == 0) ? 1 : 0);
         if (c % 2 == 0) check("mid_data", m_tdata, c / 2);
         tick();
      end
      start = 1'b0;
      check("mid_idle", idle, 1);
      check("mid_beat", beat_count, 6);
      check("mid_hold", beat_count, 6);
      kick(0, 0);
      check("zero_idle", idle, 1);
      check("zero_valid", m_tvalid, 0);
      check("zero_beat", beat_count, 0);

      // async reset mid-packet
      kick(8, 0);
      tick();
      tick();
      check("ar_d2", m_tdata, 2);
      #2 resetn = 1'b0;
      #1;
      check("ar_valid", m_tvalid, 0);
      check("ar_idle", idle, 1);
      check("ar_data", m_tdata, 0);
      check("ar_beat", beat_count, 0);
      tick();
      resetn = 1'b1;
      tick();
      check("ar_still_idle", idle, 1);
      kick(2, 0);
      check("ar2_d0", m_tdata, 0);
      check("ar2_l0", m_tlast, 0);
      tick();
      check("ar2_d1", m_tdata, 1);
      check("ar2_l1", m_tlast, 1);
      tick();
      check("ar2_idle", idle, 1);
      check("ar2_beat", beat_count, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
